// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core pipeline control.
package riscv_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with i_inc high, holds at all-ones.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count qualifying cycles, stopping at the maximum value
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: load-use stall, branch flush and
// multi-cycle WOS-op freeze with timeout escape.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_IDX_W-1:0] i_rs1_d,
    input  logic [REG_IDX_W-1:0] i_rs2_d,
    input  logic                 i_rs1_used_d,
    input  logic                 i_rs2_used_d,
    input  logic [REG_IDX_W-1:0] i_rd_e,
    input  logic                 i_mem_read_e,
    input  logic                 i_branch_taken_e,
    input  logic                 i_mc_start_e,
    input  logic                 i_mc_done,
    output logic                 o_stall_f,
    output logic                 o_stall_d,
    output logic                 o_stall_e,
    output logic                 o_flush_d,
    output logic                 o_bubble_e,
    output logic                 o_bubble_m,
    output logic                 o_mc_busy,
    output logic                 o_mc_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic [CNT_W-1:0]     o_flush_count
`endif
);

    localparam int unsigned TMR_W = $clog2(MC_TIMEOUT);

    hazard_state_t    r_state;
    hazard_state_t    w_next_state;
    logic [TMR_W-1:0] r_mc_cnt;
    logic             w_load_use;
    logic             w_timeout_hit;

    assign w_load_use = i_mem_read_e && (i_rd_e != REG_X0) &&
                        ((i_rs1_used_d && (i_rs1_d == i_rd_e)) ||
                         (i_rs2_used_d && (i_rs2_d == i_rd_e)));

    // Last wait cycle before a forced release; counter never reaches MC_TIMEOUT
    assign w_timeout_hit = (r_mc_cnt == TMR_W'(MC_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait-cycle counter, cleared whenever MC_WAIT is entered or left
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mc_cnt <= '0;
        end else if ((r_state == MC_WAIT) && (w_next_state == MC_WAIT)) begin
            r_mc_cnt <= r_mc_cnt + TMR_W'(1);
        end else begin
            r_mc_cnt <= '0;
        end
    end

    // Next-state logic; a start on the exit cycle is dropped
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (i_mc_start_e) begin
                    w_next_state = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (i_mc_done || w_timeout_hit) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // Output decode: mc_start > branch > load-use in RUN; forced to 0 in reset
    always_comb begin
        o_stall_f    = 1'b0;
        o_stall_d    = 1'b0;
        o_stall_e    = 1'b0;
        o_flush_d    = 1'b0;
        o_bubble_e   = 1'b0;
        o_bubble_m   = 1'b0;
        o_mc_busy    = 1'b0;
        o_mc_timeout = 1'b0;
        if (!i_rst) begin
            case (r_state)
                RUN: begin
                    if (i_mc_start_e) begin
                        o_stall_f  = 1'b1;
                        o_stall_d  = 1'b1;
                        o_stall_e  = 1'b1;
                        o_bubble_m = 1'b1;
                    end else if (i_branch_taken_e) begin
                        o_flush_d  = 1'b1;
                        o_bubble_e = 1'b1;
                    end else if (w_load_use) begin
                        o_stall_f  = 1'b1;
                        o_stall_d  = 1'b1;
                        o_bubble_e = 1'b1;
                    end
                end
                MC_WAIT: begin
                    o_mc_busy = 1'b1;
                    if (i_mc_done) begin
                        // result arrives: E advances this cycle
                    end else if (w_timeout_hit) begin
                        o_mc_timeout = 1'b1;
                    end else begin
                        o_stall_f  = 1'b1;
                        o_stall_d  = 1'b1;
                        o_stall_e  = 1'b1;
                        o_bubble_m = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (o_stall_f),
        .o_count (o_stall_cycles)
    );

    hazard_perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (o_flush_d),
        .o_count (o_flush_count)
    );
`endif

endmodule
